// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operation request in, registered results out.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [3:0]       i_aluc;
    logic [WIDTH-1:0] i_r;
    logic [WIDTH-1:0] i_s;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_alu;
    logic [WIDTH-1:0] o_hi;
    logic             o_zf;
    logic             o_ovf;

    modport master (
        output i_start, i_aluc, i_r, i_s,
        input  o_busy, o_done, o_alu, o_hi, o_zf, o_ovf
    );

    modport slave (
        input  i_start, i_aluc, i_r, i_s,
        output o_busy, o_done, o_alu, o_hi, o_zf, o_ovf
    );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith/shift ops and iterative shift-add MULU / restoring DIVU.
// Results are registered and held until the next o_done pulse.
module multicycle_alu #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input logic             clk,
    input logic             rst,
    multicycle_alu_if.slave bus
);
    localparam int unsigned ShW  = $clog2(WIDTH);
    localparam int unsigned CntW = ShW + 1;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSrl  = 4'b1010;
    localparam logic [3:0] OpSra  = 4'b1011;
    localparam logic [3:0] OpMulu = 4'b1100;
    localparam logic [3:0] OpDivu = 4'b1101;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] work_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   alu_q;
    logic [WIDTH-1:0]   hi_q;
    logic               zf_q;
    logic               ovf_q;

    logic               is_multi;
    logic               is_div;
    logic [ShW-1:0]     shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_alu;
    logic               sc_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    assign is_div   = (bus.i_aluc == OpDivu);
    assign is_multi = MULDIV_EN && ((bus.i_aluc == OpMulu) || is_div);

    always_comb begin
        shamt  = bus.i_s[ShW-1:0];
        sum    = bus.i_r + bus.i_s;
        diff   = bus.i_r - bus.i_s;
        sc_alu = '0;
        sc_ovf = 1'b0;
        case (bus.i_aluc)
            OpAnd:  sc_alu = bus.i_r & bus.i_s;
            OpOr:   sc_alu = bus.i_r | bus.i_s;
            OpAdd: begin
                sc_alu = sum;
                sc_ovf = (bus.i_r[WIDTH-1] == bus.i_s[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.i_r[WIDTH-1]);
            end
            OpSub: begin
                sc_alu = diff;
                sc_ovf = (bus.i_r[WIDTH-1] != bus.i_s[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.i_r[WIDTH-1]);
            end
            OpSlt:  sc_alu = {{(WIDTH-1){1'b0}}, $signed(bus.i_r) < $signed(bus.i_s)};
            OpSltu: sc_alu = {{(WIDTH-1){1'b0}}, bus.i_r < bus.i_s};
            OpSll:  sc_alu = bus.i_r << shamt;
            OpSrl:  sc_alu = bus.i_r >> shamt;
            OpSra:  sc_alu = $signed(bus.i_r) >>> shamt;
            default: sc_alu = '0;
        endcase
    end

    // work_q holds {high, low}: product accumulator / multiplier for MULU,
    // remainder / dividend-quotient for DIVU.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                    (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, opnd_q};
        // A zero divisor always "fits", which shifts r into the remainder and sets every
        // quotient bit, giving all-ones / r with the normal latency.
        if (!div_trial[WIDTH] || (opnd_q == '0)) begin
            div_next = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {work_q[2*WIDTH-2:0], 1'b0};
        end
        step_next = div_q ? div_next : mul_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alu_q   <= '0;
            hi_q    <= '0;
            zf_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        if (is_multi) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            div_q   <= is_div;
                            opnd_q  <= is_div ? bus.i_s : bus.i_r;
                            work_q  <= {{WIDTH{1'b0}}, (is_div ? bus.i_r : bus.i_s)};
                        end else begin
                            done_q <= 1'b1;
                            alu_q  <= sc_alu;
                            hi_q   <= '0;
                            zf_q   <= (sc_alu == '0);
                            ovf_q  <= sc_ovf;
                        end
                    end
                end
                StRun: begin
                    work_q <= step_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        alu_q   <= step_next[WIDTH-1:0];
                        hi_q    <= step_next[2*WIDTH-1:WIDTH];
                        zf_q    <= (step_next[WIDTH-1:0] == '0);
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_alu  = alu_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_zf   = zf_q;
    assign bus.o_ovf  = ovf_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Random + directed bench for multicycle_alu, checked every cycle against an arithmetic model.
module tb_multicycle_alu;
    localparam int unsigned W = 32;

    typedef struct {
        logic         busy;
        logic         done;
        logic [W-1:0] alu;
        logic [W-1:0] hi;
        logic         zf;
        logic         ovf;
        int           cnt;
        logic [W-1:0] palu;
        logic [W-1:0] phi;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    model_t m;
    model_t m0;

    multicycle_alu_if #(.WIDTH(W)) bus ();
    multicycle_alu_if #(.WIDTH(W)) bus0 ();

    multicycle_alu #(.WIDTH(W), .MULDIV_EN(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_alu #(.WIDTH(W), .MULDIV_EN(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s,
                                   input bit en, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                   output logic ovf, output bit multi);
        longint sr = $signed(r);
        longint ss = $signed(s);
        longint res;
        longint maxs = (longint'(1) << (W - 1)) - 1;
        longint mins = -(longint'(1) << (W - 1));
        logic [2*W-1:0] p;
        int sh = int'(s % W);
        lo = '0; hi = '0; ovf = 1'b0; multi = 1'b0;
        case (op)
            4'b0000: lo = r & s;
            4'b0001: lo = r | s;
            4'b0010: begin lo = r + s; res = sr + ss; ovf = (res > maxs) || (res < mins); end
            4'b0110: begin lo = r - s; res = sr - ss; ovf = (res > maxs) || (res < mins); end
            4'b0111: lo = (sr < ss) ? 1 : 0;
            4'b1000: lo = (r < s) ? 1 : 0;
            4'b1001: lo = r << sh;
            4'b1010: lo = r >> sh;
            4'b1011: lo = $signed(r) >>> sh;
            4'b1100: if (en) begin
                multi = 1'b1;
                p = {{W{1'b0}}, r} * {{W{1'b0}}, s};
                lo = p[W-1:0];
                hi = p[2*W-1:W];
            end
            4'b1101: if (en) begin
                multi = 1'b1;
                if (s == '0) begin lo = '1; hi = r; end
                else begin lo = r / s; hi = r % s; end
            end
            default: ;
        endcase
    endfunction

    task automatic model_adv(inout model_t mm, input logic rs, input logic st, input logic [3:0] op,
                             input logic [W-1:0] r, input logic [W-1:0] s, input bit en);
        logic [W-1:0] lo, hi;
        logic ovf;
        bit multi;
        if (!rs) begin
            mm.busy = 0; mm.done = 0; mm.alu = '0; mm.hi = '0; mm.zf = 0; mm.ovf = 0; mm.cnt = 0;
        end else begin
            mm.done = 0;
            if (mm.cnt > 0) begin
                mm.cnt--;
                if (mm.cnt == 0) begin
                    mm.busy = 0; mm.done = 1; mm.alu = mm.palu; mm.hi = mm.phi;
                    mm.zf = (mm.palu == '0); mm.ovf = 0;
                end
            end else if (st) begin
                ref_op(op, r, s, en, lo, hi, ovf, multi);
                if (multi) begin
                    mm.cnt = W; mm.busy = 1; mm.palu = lo; mm.phi = hi;
                end else begin
                    mm.done = 1; mm.alu = lo; mm.hi = hi; mm.zf = (lo == '0); mm.ovf = ovf;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input model_t mm, input logic busy, input logic done,
                       input logic [W-1:0] alu, input logic [W-1:0] hi, input logic zf,
                       input logic ovf);
        n_vec++;
        if ({busy, done, alu, hi, zf, ovf} !== {mm.busy, mm.done, mm.alu, mm.hi, mm.zf, mm.ovf}) begin
            n_err++;
            $display("FAIL %s t=%0t got busy=%b done=%b alu=%h hi=%h zf=%b ovf=%b, expected busy=%b done=%b alu=%h hi=%h zf=%b ovf=%b",
                     name, $time, busy, done, alu, hi, zf, ovf,
                     mm.busy, mm.done, mm.alu, mm.hi, mm.zf, mm.ovf);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_adv(m, rst, bus.i_start, bus.i_aluc, bus.i_r, bus.i_s, 1'b1);
        model_adv(m0, rst, bus0.i_start, bus0.i_aluc, bus0.i_r, bus0.i_s, 1'b0);
        @(negedge clk);
        cmp("dut", m, bus.o_busy, bus.o_done, bus.o_alu, bus.o_hi, bus.o_zf, bus.o_ovf);
        cmp("dut0", m0, bus0.o_busy, bus0.o_done, bus0.o_alu, bus0.o_hi, bus0.o_zf, bus0.o_ovf);
    endtask

    // Issues one op, pulses a stray ADD start mid-RUN, and waits (bounded) for o_done.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s,
                          output int lat, output int busy_n);
        bus.i_start = 1'b1; bus.i_aluc = op; bus.i_r = r; bus.i_s = s;
        step();
        bus.i_start = 1'b0;
        lat = 1;
        busy_n = int'(bus.o_busy);
        while (!bus.o_done && lat < 40) begin
            if (lat == 5) begin bus.i_start = 1'b1; bus.i_aluc = 4'b0010; end
            step();
            bus.i_start = 1'b0;
            lat++;
            busy_n += int'(bus.o_busy);
        end
        lit("done_seen", 64'(bus.o_done), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            5: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rnd_code();
        logic [3:0] codes [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                                   4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return codes[$urandom_range(0, 10)];
    endfunction

    initial begin
        int lat, busy_n, dn;
        bus.i_start = 0; bus.i_aluc = '0; bus.i_r = '0; bus.i_s = '0;
        bus0.i_start = 0; bus0.i_aluc = '0; bus0.i_r = '0; bus0.i_s = '0;
        rst = 1'b0;
        repeat (3) step();
        lit("reset_busy", 64'(bus.o_busy), 64'd0);
        lit("reset_alu", 64'(bus.o_alu), 64'd0);
        rst = 1'b1;
        step();

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, lat, busy_n);
        lit("add_lat", 64'(lat), 64'd1);
        lit("add_alu", 64'(bus.o_alu), 64'h8000_0000);
        lit("add_ovf", 64'(bus.o_ovf), 64'd1);
        lit("add_zf", 64'(bus.o_zf), 64'd0);
        run_op(4'b0110, 32'd5, 32'd5, lat, busy_n);
        lit("sub_alu", 64'(bus.o_alu), 64'd0);
        lit("sub_zf", 64'(bus.o_zf), 64'd1);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat, busy_n);
        lit("slt_alu", 64'(bus.o_alu), 64'd1);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, lat, busy_n);
        lit("sltu_alu", 64'(bus.o_alu), 64'd0);
        run_op(4'b1011, 32'h8000_0000, 32'h24, lat, busy_n);
        lit("sra_alu", 64'(bus.o_alu), 64'hF800_0000);

        run_op(4'b1100, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
        lit("mul_lat", 64'(lat), 64'd33);
        lit("mul_busy_cycles", 64'(busy_n), 64'd32);
        lit("mul_hi", 64'(bus.o_hi), 64'd1);
        lit("mul_alu", 64'(bus.o_alu), 64'hFFFF_FFFE);
        run_op(4'b1101, 32'd100, 32'd7, lat, busy_n);
        lit("div_lat", 64'(lat), 64'd33);
        lit("div_alu", 64'(bus.o_alu), 64'd14);
        lit("div_hi", 64'(bus.o_hi), 64'd2);
        run_op(4'b1101, 32'd9, 32'd0, lat, busy_n);
        lit("div0_alu", 64'(bus.o_alu), 64'hFFFF_FFFF);
        lit("div0_hi", 64'(bus.o_hi), 64'd9);

        // Back-to-back single-cycle ops: done on consecutive cycles.
        bus.i_start = 1'b1; bus.i_aluc = 4'b0001; bus.i_r = 32'hF0; bus.i_s = 32'h0F;
        step();
        lit("b2b_done1", 64'(bus.o_done), 64'd1);
        bus.i_aluc = 4'b0000;
        step();
        lit("b2b_done2", 64'(bus.o_done), 64'd1);
        lit("b2b_alu", 64'(bus.o_alu), 64'd0);
        bus.i_start = 1'b0;
        step();

        // Reset mid-RUN aborts without o_done; reset beats a simultaneous start.
        bus.i_start = 1'b1; bus.i_aluc = 4'b1100; bus.i_r = 32'd3; bus.i_s = 32'd4;
        step();
        bus.i_start = 1'b0;
        repeat (8) step();
        rst = 1'b0; bus.i_start = 1'b1; bus.i_aluc = 4'b0010;
        step();
        lit("rst_busy", 64'(bus.o_busy), 64'd0);
        lit("rst_outs", 64'({bus.o_done, bus.o_alu, bus.o_hi, bus.o_zf, bus.o_ovf}), 64'd0);
        rst = 1'b1; bus.i_start = 1'b0;
        dn = 0;
        repeat (40) begin step(); dn += int'(bus.o_done); end
        lit("rst_no_done", 64'(dn), 64'd0);
        run_op(4'b0010, 32'd2, 32'd3, lat, busy_n);
        lit("post_rst_add", 64'(bus.o_alu), 64'd5);

        run_op(4'b1111, 32'd12, 32'd34, lat, busy_n);
        lit("ill_alu", 64'(bus.o_alu), 64'd0);
        lit("ill_zf", 64'(bus.o_zf), 64'd1);
        bus0.i_start = 1'b1; bus0.i_aluc = 4'b1100; bus0.i_r = 32'd5; bus0.i_s = 32'd7;
        step();
        bus0.i_start = 1'b0;
        lit("nomd_done", 64'(bus0.o_done), 64'd1);
        lit("nomd_busy", 64'(bus0.o_busy), 64'd0);
        lit("nomd_alu", 64'(bus0.o_alu), 64'd0);
        lit("nomd_zf", 64'(bus0.o_zf), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.i_start = ($urandom_range(0, 2) == 0);
            bus.i_aluc = rnd_code(); bus.i_r = rnd_opnd(); bus.i_s = rnd_opnd();
            bus0.i_start = ($urandom_range(0, 1) == 0);
            bus0.i_aluc = rnd_code(); bus0.i_r = rnd_opnd(); bus0.i_s = rnd_opnd();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
